// File: rtl/servo_pwm_driver_if.sv
// Controller handshake bundle for servo_pwm_driver: the held sample and start strobe go out,
// and the done flag and signed servo command come back.
interface servo_pwm_driver_if #(
    parameter int unsigned WIDTH = 12
);

    logic [WIDTH-1:0]          y_k_o;
    logic                      dataf_o;
    logic                      dataf_i;
    logic signed [2*WIDTH-1:0] servo_i;

    // The driver is the master: it starts a controller computation and consumes the result.
    modport master (
        output y_k_o,
        output dataf_o,
        input  dataf_i,
        input  servo_i
    );

    modport slave (
        input  y_k_o,
        input  dataf_o,
        output dataf_i,
        output servo_i
    );

endinterface

// File: rtl/servo_pwm_driver.sv
// Servo PWM driver: once per PWM period it samples the sensor and hands it to a controller.
// It then turns the returned command into a clamped duty that takes effect at the next wrap.
module servo_pwm_driver #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned PERIOD_CYC  = 2000,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned DUTY_CENTER = 150,
    parameter int unsigned DUTY_MIN    = 100,
    parameter int unsigned DUTY_MAX    = 200,
    parameter int unsigned SHIFT       = 4
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic [WIDTH-1:0]   y_adc_i,
    servo_pwm_driver_if.master ctl,
    output logic               pwm_o,
    output logic [WIDTH-1:0]   duty_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int unsigned CmdW = 2 * WIDTH;
    localparam int unsigned RawW = WIDTH + 2;

    localparam logic [15:0] CntLast  = 16'(PERIOD_CYC - 1);
    localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYC - 1);

    localparam logic signed [CmdW-1:0] SatHi = CmdW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [CmdW-1:0] SatLo = ~SatHi;

    localparam logic signed [RawW-1:0] RawCenter = RawW'(DUTY_CENTER);
    localparam logic signed [RawW-1:0] RawMin    = RawW'(DUTY_MIN);
    localparam logic signed [RawW-1:0] RawMax    = RawW'(DUTY_MAX);

    localparam logic [WIDTH-1:0] DutyCenter = WIDTH'(DUTY_CENTER);
    localparam logic [WIDTH-1:0] DutyMin    = WIDTH'(DUTY_MIN);
    localparam logic [WIDTH-1:0] DutyMax    = WIDTH'(DUTY_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StUpdate
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [15:0]             r_count;
    logic [15:0]             r_wait;
    logic                    r_pwm;
    logic [WIDTH-1:0]        r_duty;
    logic [WIDTH-1:0]        r_shadow;
    logic [WIDTH-1:0]        r_y_k;
    logic signed [CmdW-1:0]  r_cmd;
    logic                    r_err;

    logic                    w_wrap;
    logic                    w_accept;
    logic                    w_timeout;
    logic signed [WIDTH-1:0] w_sat;
    logic signed [WIDTH-1:0] w_off;
    logic signed [RawW-1:0]  w_raw;
    logic [WIDTH-1:0]        w_duty_new;

    assign w_wrap    = (r_count == CntLast);
    assign w_accept  = (r_state == StWait) && ctl.dataf_i;
    assign w_timeout = (r_state == StWait) && !ctl.dataf_i && (r_wait == WaitLast);

    // Period counter
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    // Active duty only reloads at the period boundary so a pulse is never cut short.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_duty <= DutyCenter;
            r_pwm  <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_duty <= r_shadow;
            end
            r_pwm <= (32'(r_count) < 32'(r_duty));
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_wrap) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                w_state_next = StWait;
            end
            StWait: begin
                if (ctl.dataf_i) begin
                    w_state_next = StUpdate;
                end else if (r_wait == WaitLast) begin
                    w_state_next = StIdle;
                end
            end
            StUpdate: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        ctl.dataf_o = 1'b0;
        busy_o      = 1'b0;
        unique case (r_state)
            StStart: begin
                ctl.dataf_o = 1'b1;
                busy_o      = 1'b1;
            end
            StWait: begin
                busy_o = 1'b1;
            end
            default: begin
                ctl.dataf_o = 1'b0;
                busy_o      = 1'b0;
            end
        endcase
    end

    // WAIT dwell counter; it restarts every time WAIT is entered.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (r_state == StWait) begin
            r_wait <= r_wait + 16'd1;
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_y_k    <= '0;
            r_cmd    <= '0;
            r_shadow <= DutyCenter;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == StIdle) && w_wrap) begin
                r_y_k <= y_adc_i;
            end
            if (w_accept) begin
                r_cmd <= ctl.servo_i;
            end
            if (r_state == StUpdate) begin
                r_shadow <= w_duty_new;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Command to duty: saturate to the sample range, scale down, offset, clamp to servo limits.
    always_comb begin
        if (r_cmd > SatHi) begin
            w_sat = SatHi[WIDTH-1:0];
        end else if (r_cmd < SatLo) begin
            w_sat = SatLo[WIDTH-1:0];
        end else begin
            w_sat = r_cmd[WIDTH-1:0];
        end
    end

    assign w_off = w_sat >>> SHIFT;
    assign w_raw = RawCenter + $signed({{2{w_off[WIDTH-1]}}, w_off});

    always_comb begin
        if (w_raw < RawMin) begin
            w_duty_new = DutyMin;
        end else if (w_raw > RawMax) begin
            w_duty_new = DutyMax;
        end else begin
            w_duty_new = w_raw[WIDTH-1:0];
        end
    end

    assign ctl.y_k_o = r_y_k;
    assign pwm_o     = r_pwm;
    assign duty_o    = r_duty;
    assign err_o     = r_err;

endmodule

// File: doc/servo_pwm_driver.md
SERVO_PWM_DRIVER -- requirements
Module: servo_pwm_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the sample width; the command width SHALL be 2*WIDTH.
REQ-002 The block SHALL have parameter PERIOD_CYC, default 2000, giving clock cycles per PWM and sample period (at most 65535).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 64, giving the maximum WAIT cycles; TIMEOUT_CYC SHALL be at most PERIOD_CYC-4.
REQ-004 The block SHALL have parameters DUTY_CENTER=150, DUTY_MIN=100 and DUTY_MAX=200, giving duty in cycles, with DUTY_MIN<=DUTY_CENTER<=DUTY_MAX<PERIOD_CYC.
REQ-005 The block SHALL have parameter SHIFT, default 4, giving the arithmetic right shift applied to the saturated command.
REQ-006 The block SHALL have input clk_i, 1 bit, the clock.
REQ-007 The block SHALL have input reset, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have input y_adc_i, WIDTH bits, the raw sensor sample.
REQ-009 The block SHALL have output y_k_o, WIDTH bits, the sample held for the controller.
REQ-010 The block SHALL have output dataf_o, 1 bit, the start strobe to the controller.
REQ-011 The block SHALL have input dataf_i, 1 bit, the controller-done indication.
REQ-012 The block SHALL have input servo_i, 2*WIDTH bits signed, the controller command.
REQ-013 The block SHALL have output pwm_o, 1 bit, the servo PWM.
REQ-014 The block SHALL have output duty_o, WIDTH bits unsigned, the currently active duty.
REQ-015 The block SHALL have output busy_o, 1 bit, high while in the START or WAIT state.
REQ-016 The block SHALL have output err_o, 1 bit, a sticky controller-timeout flag.

Function
REQ-017 The period counter SHALL count 0..PERIOD_CYC-1 and wrap to 0; "wrap" SHALL mean the cycle in which count==PERIOD_CYC-1.
REQ-018 On wrap, the active duty (duty_o) SHALL load from the shadow duty, so that it changes only at a period boundary.
REQ-019 pwm_o SHALL be a registered output, high for count 0..duty_o-1 and low otherwise, i.e. exactly duty_o high cycles per period, delayed one cycle from the counter.
REQ-020 The FSM states SHALL be IDLE, START, WAIT and UPDATE; no other states SHALL be reachable.
REQ-021 In IDLE, on wrap, the FSM SHALL go to START and register y_adc_i into y_k_o on that same edge.
REQ-022 START SHALL drive dataf_o=1 for exactly one cycle, ignore dataf_i, and go to WAIT.
REQ-023 In WAIT, when dataf_i==1 the FSM SHALL capture servo_i on that edge and go to UPDATE.
REQ-024 In WAIT, after TIMEOUT_CYC cycles without dataf_i, the FSM SHALL set err_o=1 and return to IDLE with the shadow duty unchanged.
REQ-025 If dataf_i==1 arrives in the final timeout cycle, dataf_i SHALL win: capture, no error.
REQ-026 In UPDATE, the block SHALL write the new duty to the shadow register and go to IDLE; this takes one cycle.
REQ-027 dataf_i SHALL be ignored in the IDLE, START and UPDATE states.
REQ-028 Duty arithmetic step 1: sat = servo_i clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-029 Duty arithmetic step 2: off = sat >>> SHIFT, an arithmetic shift that floors toward negative infinity.
REQ-030 Duty arithmetic step 3: raw = DUTY_CENTER + off, computed signed in WIDTH+2 bits.
REQ-031 Duty arithmetic step 4: duty = raw clamped to [DUTY_MIN, DUTY_MAX].
REQ-032 Latency from dataf_i capture to the shadow update SHALL be 1 cycle; the new duty SHALL appear on duty_o/pwm_o at the next wrap.
REQ-033 y_k_o SHALL be held stable from START until the next START.

Reset
REQ-034 While reset is high, the block SHALL hold: FSM=IDLE, count=0, dataf_o=0, y_k_o=0, pwm_o=0, busy_o=0, err_o=0, shadow=DUTY_CENTER and duty_o=DUTY_CENTER.
REQ-035 Reset asserted mid-WAIT SHALL abort the transaction and discard any pending command.
REQ-036 err_o SHALL clear only on reset.
REQ-037 After reset deasserts, the first START SHALL occur at the first wrap, PERIOD_CYC-1 cycles later.

Verification
REQ-038 Scenario: reset, no activity -> pwm_o high exactly 150 cycles per 2000-cycle period; dataf_o pulses once per period, one cycle wide.
REQ-039 Scenario: y_adc_i=0x3A5, responder returns dataf_i 5 cycles after dataf_o with servo_i=800 -> y_k_o=0x3A5; next period duty_o=200.
REQ-040 Scenario: servo_i=-320 -> 130; servo_i=-1000 -> 100 (clamp); servo_i=0x7FFFFF -> 200 (saturate then clamp); servo_i=0 -> 150.
REQ-041 Scenario: responder never answers -> err_o=1 after 64 WAIT cycles, busy_o falls, duty_o unchanged, next period restarts normally.
REQ-042 Scenario: dataf_i held high during START and IDLE, and dataf_i arriving in the 64th WAIT cycle -> ignored in START/IDLE; accepted in the 64th cycle with err_o staying 0.
REQ-043 Scenario: reset pulsed 3 cycles into WAIT with servo_i=800 pending -> all outputs at reset values; duty_o stays 150 in the following period.
